// File: rtl/cdc_sync_edge.sv
// Multi-channel level synchronizer with registered rise/fall/any-edge pulses.
// Optional per-channel glitch filter compiled in with CDC_SYNC_FILTER_EN.
module cdc_sync_edge #(
    parameter int   pCHANNELS = 4,
    parameter int   pSTAGES   = 2,
    parameter logic pRST_VAL  = 1'b0,
    parameter int   pFILT_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [pCHANNELS-1:0] d,
    output logic [pCHANNELS-1:0] q,
    output logic [pCHANNELS-1:0] rise,
    output logic [pCHANNELS-1:0] fall,
    output logic                 any_edge
);

    if (pCHANNELS < 1 || pCHANNELS > 32) begin : g_bad_ch
        $error("pCHANNELS out of range");
    end
    if (pSTAGES < 2 || pSTAGES > 4) begin : g_bad_st
        $error("pSTAGES out of range");
    end
    if (pFILT_LEN < 2 || pFILT_LEN > 255) begin : g_bad_fl
        $error("pFILT_LEN out of range");
    end

    logic [pSTAGES-1:0][pCHANNELS-1:0] chain;
    logic [pCHANNELS-1:0]              sync;
    logic [pCHANNELS-1:0]              rise_n;
    logic [pCHANNELS-1:0]              fall_n;

    // d feeds the first stage directly; nothing sits in front of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {(pSTAGES*pCHANNELS){pRST_VAL}};
        end else begin
            chain <= {chain[pSTAGES-2:0], d};
        end
    end

    assign sync = chain[pSTAGES-1];

`ifdef CDC_SYNC_FILTER_EN
    localparam int CW = $clog2(pFILT_LEN + 1);

    logic [pCHANNELS-1:0] q_r;
    logic [pCHANNELS-1:0] upd;
    logic [CW-1:0]        cnt   [pCHANNELS];
    logic [CW-1:0]        cnt_n [pCHANNELS];

    always_comb begin
        upd = '0;
        for (int i = 0; i < pCHANNELS; i++) begin
            cnt_n[i] = '0;
            if (sync[i] != q_r[i]) begin
                // the edge completing pFILT_LEN differing cycles commits
                if (cnt[i] >= CW'(pFILT_LEN - 1)) begin
                    upd[i] = 1'b1;
                end else begin
                    cnt_n[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {pCHANNELS{pRST_VAL}};
            for (int i = 0; i < pCHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q_r <= q_r ^ upd;
            for (int i = 0; i < pCHANNELS; i++) begin
                cnt[i] <= cnt_n[i];
            end
        end
    end

    assign rise_n = upd & sync;
    assign fall_n = upd & ~sync;
    assign q      = q_r;
`else
    // the stage feeding the last one is next cycle's q
    assign rise_n = chain[pSTAGES-2] & ~chain[pSTAGES-1];
    assign fall_n = ~chain[pSTAGES-2] & chain[pSTAGES-1];
    assign q      = sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise     <= '0;
            fall     <= '0;
            any_edge <= 1'b0;
        end else begin
            rise     <= rise_n;
            fall     <= fall_n;
            any_edge <= |(rise_n | fall_n);
        end
    end

endmodule

// File: tb/tb_cdc_sync_edge.sv
// Scoreboard bench for cdc_sync_edge: randomized and directed level stimulus
// against a queue-based reference model; filter model follows CDC_SYNC_FILTER_EN.
module tb_cdc_sync_edge;

    localparam int   C = 4;
    localparam int   S = 3;
    localparam logic R = 1'b1;
    localparam int   F = 4;

    typedef struct packed {
        logic [C-1:0] q;
        logic [C-1:0] r;
        logic [C-1:0] f;
        logic         a;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [C-1:0] d;
    logic [C-1:0] q;
    logic [C-1:0] rise;
    logic [C-1:0] fall;
    logic         any_edge;

    cdc_sync_edge #(
        .pCHANNELS(C),
        .pSTAGES  (S),
        .pRST_VAL (R),
        .pFILT_LEN(F)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (d),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .any_edge(any_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         sb [$];
    logic [C-1:0] hist [$];
    logic [C-1:0] mq;
    int           mcnt [C];
    int           vec;
    int           miss;

    task automatic mdl_reset(output exp_t e);
        hist.delete();
        mq = {C{R}};
        for (int i = 0; i < C; i++) mcnt[i] = 0;
        e.q = {C{R}};
        e.r = '0;
        e.f = '0;
        e.a = 1'b0;
    endtask

    // q after an edge is d sampled S-1 edges earlier (optionally debounced)
    task automatic mdl_step(input logic [C-1:0] de, output exp_t e);
        logic [C-1:0] so;
        logic [C-1:0] nq;
        hist.push_back(de);
        if (hist.size() > S) hist.delete(0);
        so = (hist.size() == S) ? hist[0] : {C{R}};
`ifdef CDC_SYNC_FILTER_EN
        nq = mq;
        for (int i = 0; i < C; i++) begin
            if (so[i] != mq[i]) begin
                mcnt[i]++;
                if (mcnt[i] == F) begin
                    nq[i] = so[i];
                    mcnt[i] = 0;
                end
            end else begin
                mcnt[i] = 0;
            end
        end
`else
        nq = so;
`endif
        e.q = nq;
        e.r = nq & ~mq;
        e.f = ~nq & mq;
        e.a = |(e.r | e.f);
        mq = nq;
    endtask

    task automatic cyc(input logic [C-1:0] nd, input logic nr);
        logic [C-1:0] de;
        logic         re;
        exp_t         e;
        @(posedge clk);
        #1;
        de = d;
        re = rst_n;
        if (!nr && re) begin
            rst_n = 1'b0;
            mdl_reset(e);
        end else begin
            if (!re) mdl_reset(e);
            else mdl_step(de, e);
            rst_n = nr;
        end
        sb.push_back(e);
        d = nd;
    endtask

    task automatic hold(input logic [C-1:0] nd, input int n);
        for (int k = 0; k < n; k++) cyc(nd, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vec++;
            if (q !== e.q || rise !== e.r || fall !== e.f
                || any_edge !== e.a) begin
                miss++;
                $display("FAIL outputs vec %0d t=%0t: got q=%b rise=%b fall=%b any=%b, expected q=%b rise=%b fall=%b any=%b",
                         vec, $time, q, rise, fall, any_edge,
                         e.q, e.r, e.f, e.a);
            end
        end
    end

    initial begin
        logic [C-1:0] rd;
        vec   = 0;
        miss  = 0;
        rst_n = 1'b0;
        d     = '0;
        for (int k = 0; k < 5; k++) cyc('0, 1'b0);
        cyc('0, 1'b1);
        hold('0, 14);
        hold(4'b0101, 14);
        hold(4'b1010, 14);
        hold('0, 14);
        hold(4'b0001, 3);
        hold('0, 14);
        hold(4'b0001, 6);
        hold('0, 14);
        hold(4'b1111, S + 2);
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b0);
        cyc(4'b1111, 1'b1);
        hold(4'b1111, 14);
        for (int k = 0; k < 20; k++) cyc((k % 2 == 0) ? 4'b0000 : 4'b1111, 1'b1);
        hold('0, 10);
        for (int k = 0; k < 150; k++) begin
            rd = C'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                cyc(rd, 1'b0);
                cyc(rd, 1'b1);
            end else begin
                hold(rd, $urandom_range(1, 8));
            end
        end
        hold('0, 10);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miss++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/cdc_sync_edge.md
CDC_SYNC_EDGE -- requirements
Module: cdc_sync_edge

Interface
REQ-001 pCHANNELS, default 4: number of independent asynchronous input channels (1..32).
REQ-002 pSTAGES, default 2: synchronizer flip-flop depth per channel (2..4).
REQ-003 pRST_VAL, default 0: reset value of every synchronizer stage, every q bit, and the filter reference (0 or 1, all channels alike).
REQ-004 pFILT_LEN, default 4: filter length in clk cycles (2..255); used only when CDC_SYNC_FILTER_EN is defined.
REQ-005 clk  input  1  destination-domain clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 d  input  pCHANNELS  asynchronous level inputs, no timing relation to clk.
REQ-008 q  output  pCHANNELS  synchronized (and optionally filtered) levels.
REQ-009 rise  output  pCHANNELS  one-cycle pulse per channel on q 0->1.
REQ-010 fall  output  pCHANNELS  one-cycle pulse per channel on q 1->0.
REQ-011 any_edge  output  1  OR of all rise and fall bits in the same cycle.

Function
REQ-012 Each channel shall pass d[i] through a chain of pSTAGES flops clocked by clk; d[i] shall be sampled by the first stage only, with no logic ahead of it.
REQ-013 Channels shall be fully independent; no channel's state shall affect another channel's outputs.
REQ-014 Without filter, q[i] shall equal the last chain stage; a d change stable across the sampling edge shall appear on q after exactly pSTAGES rising clk edges.
REQ-015 q, rise, fall and any_edge shall be registered outputs, with no combinational path from d.
REQ-016 rise[i] shall be high for exactly one cycle, the first cycle in which q[i] reads 1 after reading 0; fall[i] likewise for 1->0.
REQ-017 rise[i] and fall[i] shall never be high in the same cycle; a d pulse shorter than one clk period may be lost, but any q change shall always produce exactly one edge pulse.
REQ-018 Simultaneous edges on several channels shall each pulse their own rise/fall bits in the same cycle; any_edge shall be a single one-cycle pulse for that cycle.
REQ-019 Toggling d[i] every clk cycle shall produce, on q[i], a delayed copy with pulses every cycle, and no metastability-induced X at q in RTL simulation.

Reset
REQ-020 While rst_n is low, all stages and q shall hold pRST_VAL; rise, fall, any_edge and filter counters shall be 0.
REQ-021 Assertion shall take effect immediately, without a clk edge; reset mid-operation shall discard in-flight values and any counter progress.
REQ-022 The first cycles after deassertion shall not generate rise/fall pulses unless q actually leaves pRST_VAL under REQ-014 or REQ-026.

Configuration
REQ-023 Macro CDC_SYNC_FILTER_EN shall compile a per-channel glitch filter between the chain output and q.
REQ-024 With filter: a per-channel counter of width ceil(log2(pFILT_LEN+1)) shall increment each cycle the chain output differs from q[i], and shall clear in any cycle it equals q[i].
REQ-025 With filter: a chain-output change lasting fewer than pFILT_LEN consecutive cycles shall leave q[i], rise[i], fall[i] unchanged.
REQ-026 With filter: q[i] shall update, and the counter clear, on the edge completing pFILT_LEN consecutive differing cycles; total latency d->q = pSTAGES + pFILT_LEN edges; the counter shall saturate, never wrap.
REQ-027 Without the macro, no filter counters shall be synthesized; behaviour shall be per REQ-014; pFILT_LEN shall be ignored.

Verification
REQ-028 Reset: pRST_VAL=1, hold rst_n low 5 cycles with d=0, release -> q=1 during reset, q falls after 2 edges, exactly one fall pulse per channel, none during reset.
REQ-029 Latency: pSTAGES=3, no filter, d[0] 0->1 before edge N -> q[0]=1 after edge N+2, rise[0] and any_edge high that one cycle only.
REQ-030 Multi-channel: d=4'b0101 -> 4'b1010 at once -> rise=4'b1010, fall=4'b0101 same cycle, any_edge one cycle.
REQ-031 Filter on, pFILT_LEN=4: 3-cycle d high pulse -> q, rise unchanged; 6-cycle pulse -> q high after 2+4 edges, one rise, then one fall.
REQ-032 Reset mid-filter: filter on, drop rst_n after 2 differing cycles -> q=pRST_VAL immediately, counter 0, no pulse after release unless d held 4 further cycles.
